// File: rtl/cpe_pkg.sv
// cpe_pkg
// Shared constants and types for the register-file write-back slice.
//   ADDR_W / DATA_W / NUM_REGS : register file geometry
//   gnt_id_e                   : identifies which write-back path owns the port
package cpe_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  // Requester identity, remembered by the arbiter as the most recent winner
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } gnt_id_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way arbiter with a last-grant register. In round-robin mode a
// conflict goes to whichever side did not win most recently; in fixed
// mode the mem side always wins a conflict. A lone request is always
// granted in the same cycle.
// Ports:
//   clk_w_i       clock
//   res_w_i_h     synchronous active-high reset; forces both grants low
//   alu_req_w_i   request from the ALU result path
//   mem_req_w_i   request from the memory load path
//   alu_gnt_w_o   combinational grant to the ALU path
//   mem_gnt_w_o   combinational grant to the memory path
module rr_arb2
  import cpe_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic clk_w_i,
  input  logic res_w_i_h,
  input  logic alu_req_w_i,
  input  logic mem_req_w_i,
  output logic alu_gnt_w_o,
  output logic mem_gnt_w_o
);

  gnt_id_e last_gnt_r;

  // Grant decode. Reset suppresses grants so nothing is consumed while the
  // write port is being cleared.
  always_comb begin
    alu_gnt_w_o = 1'b0;
    mem_gnt_w_o = 1'b0;
    if (!res_w_i_h) begin
      if (alu_req_w_i && mem_req_w_i) begin
        if ((RR_EN != 0) && (last_gnt_r == GNT_MEM)) begin
          alu_gnt_w_o = 1'b1;
        end else begin
          mem_gnt_w_o = 1'b1;
        end
      end else begin
        alu_gnt_w_o = alu_req_w_i;
        mem_gnt_w_o = mem_req_w_i;
      end
    end
  end

  // Remember the last winner. Starting at MEM lets the ALU take the
  // first conflict after reset.
  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      last_gnt_r <= GNT_MEM;
    end else if (alu_gnt_w_o) begin
      last_gnt_r <= GNT_ALU;
    end else if (mem_gnt_w_o) begin
      last_gnt_r <= GNT_MEM;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Write-back controller for the register file. Shares the single write
// port between the ALU and memory paths and keeps a busy scoreboard of
// in-flight destinations so issue can stall on RAW/WAW hazards.
// Ports:
//   clk_w_i, res_w_i_h            clock, synchronous active-high reset
//   issue_valid_w_i/issue_rd_w_i  issuing instruction and its destination
//   rs1_w_i, rs2_w_i              sources of the issuing instruction
//   hazard_w_o                    a source is busy (combinational)
//   issue_stall_w_o               issue must hold (combinational)
//   alu_*/mem_*                   write-back request/target/data/grant
//   wr_reg_w_o/wr_data_w_o        registered write index and data
//   reg_wr_flag_w_o               registered write enable, one pulse per write
//   busy_vec_r_o                  scoreboard contents
module regfile_wb_arbiter #(
  parameter int NUM_REGS = cpe_pkg::NUM_REGS,
  parameter int ADDR_W   = cpe_pkg::ADDR_W,
  parameter int DATA_W   = cpe_pkg::DATA_W,
  parameter int RR_EN    = 1
) (
  input  logic                clk_w_i,
  input  logic                res_w_i_h,
  input  logic                issue_valid_w_i,
  input  logic [ADDR_W-1:0]   issue_rd_w_i,
  input  logic [ADDR_W-1:0]   rs1_w_i,
  input  logic [ADDR_W-1:0]   rs2_w_i,
  output logic                hazard_w_o,
  output logic                issue_stall_w_o,
  input  logic                alu_req_w_i,
  input  logic [ADDR_W-1:0]   alu_rd_w_i,
  input  logic [DATA_W-1:0]   alu_data_w_i,
  input  logic                mem_req_w_i,
  input  logic [ADDR_W-1:0]   mem_rd_w_i,
  input  logic [DATA_W-1:0]   mem_data_w_i,
  output logic                alu_gnt_w_o,
  output logic                mem_gnt_w_o,
  output logic [ADDR_W-1:0]   wr_reg_w_o,
  output logic [DATA_W-1:0]   wr_data_w_o,
  output logic                reg_wr_flag_w_o,
  output logic [NUM_REGS-1:0] busy_vec_r_o
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_next;
  logic                any_gnt;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;
  logic                issue_accept;

  rr_arb2 #(
    .RR_EN (RR_EN)
  ) u_arb (
    .clk_w_i     (clk_w_i),
    .res_w_i_h   (res_w_i_h),
    .alu_req_w_i (alu_req_w_i),
    .mem_req_w_i (mem_req_w_i),
    .alu_gnt_w_o (alu_gnt_w_o),
    .mem_gnt_w_o (mem_gnt_w_o)
  );

  // Hazard detection. No bypass exists, so a source stays hazardous until
  // its busy bit clears at the end of the write-enable cycle.
  always_comb begin
    hazard_w_o      = busy_r[rs1_w_i] | busy_r[rs2_w_i];
    issue_stall_w_o = !res_w_i_h && issue_valid_w_i &&
                      (hazard_w_o || busy_r[issue_rd_w_i]);
    issue_accept    = issue_valid_w_i && !issue_stall_w_o &&
                      (issue_rd_w_i != '0);
  end

  // Write-port source select follows whichever path holds the grant.
  always_comb begin
    any_gnt  = alu_gnt_w_o | mem_gnt_w_o;
    sel_rd   = mem_gnt_w_o ? mem_rd_w_i   : alu_rd_w_i;
    sel_data = mem_gnt_w_o ? mem_data_w_i : alu_data_w_i;
  end

  // Scoreboard update. The clear is applied first so a same-index set
  // would win; busy[0] is forced low since x0 is never written.
  always_comb begin
    busy_next = busy_r;
    if (reg_wr_flag_w_o) begin
      busy_next[wr_reg_w_o] = 1'b0;
    end
    if (issue_accept) begin
      busy_next[issue_rd_w_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_next;
    end
  end

  // Write port registers. A grant to x0 is consumed without raising the
  // write enable, so neither the register file nor the scoreboard moves.
  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      wr_reg_w_o      <= '0;
      wr_data_w_o     <= '0;
      reg_wr_flag_w_o <= 1'b0;
    end else begin
      reg_wr_flag_w_o <= any_gnt && (sel_rd != '0);
      if (any_gnt) begin
        wr_reg_w_o  <= sel_rd;
        wr_data_w_o <= sel_data;
      end
    end
  end

  assign busy_vec_r_o = busy_r;

endmodule
